// File: rtl/coeff_token_encoder.sv
// coeff_token_encoder: CAVLC coeff_token encoder.
// Handshakes: a transfer happens on any rising edge where valid && ready are
// both high. The source holds valid and its payload stable until that edge.
// The symbol side uses inValid/inReady. The serial side uses outValid/outReady.
// FLC and Chroma-DC codes come from internal tables. VLC0/1/2 codes come from an
// external table through lutSel/lutAddr -> lutCode/lutLen.
module coeff_token_encoder #(
  parameter int CODE_W       = 16,
  parameter int LEN_W        = 5,
  parameter int NC_W         = 5,
  parameter bit CHROMA_DC_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inValid,
  output logic              inReady,
  input  logic [4:0]        totalCoeff,
  input  logic [1:0]        trailingOnes,
  input  logic              chromaDc,
  input  logic              availA,
  input  logic              availB,
  input  logic [NC_W-1:0]   nA,
  input  logic [NC_W-1:0]   nB,
  output logic [6:0]        lutAddr,
  output logic [1:0]        lutSel,
  input  logic [CODE_W-1:0] lutCode,
  input  logic [LEN_W-1:0]  lutLen,
  output logic [CODE_W-1:0] codeQ,
  output logic [LEN_W-1:0]  lenQ,
  output logic [1:0]        tblSelQ,
  output logic              outBit,
  output logic              outValid,
  output logic              outLast,
  input  logic              outReady,
  output logic              errPulse,
  output logic [1:0]        state_dbg
);

  localparam int IDX_W = $clog2(CODE_W);
  localparam logic [NC_W:0] NC_2 = (NC_W+1)'(2);
  localparam logic [NC_W:0] NC_4 = (NC_W+1)'(4);
  localparam logic [NC_W:0] NC_8 = (NC_W+1)'(8);

  typedef enum logic [1:0] {IDLE = 2'd0, LOOKUP = 2'd1, SHIFT = 2'd2} state_t;

  state_t            state;
  logic [4:0]        tc_r;
  logic [1:0]        t1_r;
  logic              cdc_r;
  logic              avail_a_r;
  logic              avail_b_r;
  logic [NC_W-1:0]   na_r;
  logic [NC_W-1:0]   nb_r;
  logic [LEN_W-1:0]  count;

  logic [NC_W:0]     nc_sum;
  logic [NC_W:0]     nc;
  logic [1:0]        tbl_sel;
  logic [3:0]        tc_m1;
  logic [11:0]       cdc_entry;
  logic [CODE_W-1:0] code_nxt;
  logic [LEN_W-1:0]  len_nxt;
  logic              bad;
  logic [IDX_W-1:0]  bit_idx;

  // Chroma DC 2x2 coeff_token table, returns {len[3:0], code[7:0]}; len 0 = undefined.
  function automatic logic [11:0] chroma_lut(input logic [1:0] t1, input logic [4:0] tc);
    logic [11:0] r;
    case ({t1, tc})
      {2'd0, 5'd0}: r = {4'd2, 8'b00000001};
      {2'd0, 5'd1}: r = {4'd6, 8'b00000111};
      {2'd1, 5'd1}: r = {4'd1, 8'b00000001};
      {2'd0, 5'd2}: r = {4'd6, 8'b00000100};
      {2'd1, 5'd2}: r = {4'd6, 8'b00000110};
      {2'd2, 5'd2}: r = {4'd3, 8'b00000001};
      {2'd0, 5'd3}: r = {4'd6, 8'b00000011};
      {2'd1, 5'd3}: r = {4'd7, 8'b00000011};
      {2'd2, 5'd3}: r = {4'd7, 8'b00000010};
      {2'd3, 5'd3}: r = {4'd6, 8'b00000101};
      {2'd0, 5'd4}: r = {4'd6, 8'b00000010};
      {2'd1, 5'd4}: r = {4'd8, 8'b00000011};
      {2'd2, 5'd4}: r = {4'd8, 8'b00000010};
      {2'd3, 5'd4}: r = {4'd7, 8'b00000000};
      default:      r = 12'd0;
    endcase
    return r;
  endfunction

  // nC derivation and table selection from the registered symbol.
  always_comb begin
    nc_sum = {1'b0, na_r} + {1'b0, nb_r} + {{NC_W{1'b0}}, 1'b1};
    if (avail_a_r && avail_b_r) nc = nc_sum >> 1;
    else if (avail_a_r)         nc = {1'b0, na_r};
    else if (avail_b_r)         nc = {1'b0, nb_r};
    else                        nc = '0;

    if (cdc_r || nc >= NC_8) tbl_sel = 2'd3;
    else if (nc >= NC_4)     tbl_sel = 2'd2;
    else if (nc >= NC_2)     tbl_sel = 2'd1;
    else                     tbl_sel = 2'd0;

    lutSel  = (tbl_sel == 2'd3) ? 2'd0 : tbl_sel;
    lutAddr = {t1_r, tc_r};
  end

  // Codeword formation and symbol validity for the LOOKUP cycle.
  always_comb begin
    tc_m1     = 4'(tc_r - 5'd1);
    cdc_entry = chroma_lut(t1_r, tc_r);
    if (tbl_sel != 2'd3) begin
      code_nxt = lutCode;
      len_nxt  = lutLen;
    end else if (cdc_r) begin
      code_nxt = CODE_W'(cdc_entry[7:0]);
      len_nxt  = LEN_W'(cdc_entry[11:8]);
    end else begin
      code_nxt = (tc_r == 5'd0) ? CODE_W'(6'b000011) : CODE_W'({tc_m1, t1_r});
      len_nxt  = LEN_W'(6);
    end

    bad = ({3'b000, t1_r} > tc_r) || (tc_r > 5'd16) || (cdc_r && tc_r > 5'd4);
    if (tbl_sel != 2'd3 && (lutLen == '0 || 32'(lutLen) > CODE_W)) bad = 1'b1;
  end

  // Control FSM: accept, look up / validate, then shift the codeword out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tc_r      <= '0;
      t1_r      <= '0;
      cdc_r     <= 1'b0;
      avail_a_r <= 1'b0;
      avail_b_r <= 1'b0;
      na_r      <= '0;
      nb_r      <= '0;
      count     <= '0;
      codeQ     <= '0;
      lenQ      <= '0;
      tblSelQ   <= '0;
      errPulse  <= 1'b0;
    end else begin
      errPulse <= 1'b0;
      case (state)
        IDLE: begin
          if (inValid) begin
            tc_r      <= totalCoeff;
            t1_r      <= trailingOnes;
            cdc_r     <= chromaDc & CHROMA_DC_EN;
            avail_a_r <= availA;
            avail_b_r <= availB;
            na_r      <= nA;
            nb_r      <= nB;
            state     <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (bad) begin
            errPulse <= 1'b1;
            state    <= IDLE;
          end else begin
            codeQ   <= code_nxt;
            lenQ    <= len_nxt;
            tblSelQ <= tbl_sel;
            count   <= len_nxt;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (outReady) begin
            count <= count - 1'b1;
            if (count == LEN_W'(1)) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Serial outputs are decoded from registered state only.
  always_comb begin
    bit_idx   = IDX_W'(count - 1'b1);
    inReady   = (state == IDLE);
    outValid  = (state == SHIFT);
    outBit    = outValid & codeQ[bit_idx];
    outLast   = outValid && (count == LEN_W'(1));
    state_dbg = state;
  end

endmodule

// File: tb/tb_coeff_token_encoder.sv
// Bench for coeff_token_encoder: directed cases plus randomized symbols against a
// string-based reference model of the coeff_token tables.
module tb_coeff_token_encoder;
  localparam int CODE_W = 16;
  localparam int LEN_W  = 5;
  localparam int NC_W   = 5;

  // Clock and reset.
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              inValid = 1'b0;
  logic              inReady;
  logic [4:0]        totalCoeff = '0;
  logic [1:0]        trailingOnes = '0;
  logic              chromaDc = 1'b0;
  logic              availA = 1'b0;
  logic              availB = 1'b0;
  logic [NC_W-1:0]   nA = '0;
  logic [NC_W-1:0]   nB = '0;
  logic [6:0]        lutAddr;
  logic [1:0]        lutSel;
  logic [CODE_W-1:0] lutCode = '0;
  logic [LEN_W-1:0]  lutLen = '0;
  logic [CODE_W-1:0] codeQ;
  logic [LEN_W-1:0]  lenQ;
  logic [1:0]        tblSelQ;
  logic              outBit;
  logic              outValid;
  logic              outLast;
  logic              outReady = 1'b0;
  logic              errPulse;
  logic [1:0]        state_dbg;

  coeff_token_encoder #(.CODE_W(CODE_W), .LEN_W(LEN_W), .NC_W(NC_W), .CHROMA_DC_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .inValid(inValid), .inReady(inReady),
    .totalCoeff(totalCoeff), .trailingOnes(trailingOnes), .chromaDc(chromaDc),
    .availA(availA), .availB(availB), .nA(nA), .nB(nB),
    .lutAddr(lutAddr), .lutSel(lutSel), .lutCode(lutCode), .lutLen(lutLen),
    .codeQ(codeQ), .lenQ(lenQ), .tblSelQ(tblSelQ),
    .outBit(outBit), .outValid(outValid), .outLast(outLast), .outReady(outReady),
    .errPulse(errPulse), .state_dbg(state_dbg)
  );

  int checks = 0;
  int errors = 0;

  // Scoreboard state.
  logic [0:0]        exp_q[$];
  string             cd_tab[4][5];
  logic [CODE_W-1:0] last_code = '0;
  logic [LEN_W-1:0]  last_len = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one symbol and follow it to completion.
  // stall_mode: 0 = always ready, 1 = random ready, 2 = 3-cycle stall after 2nd bit.
  task automatic run_sym(input int tc, input int t1, input int cdc, input int aa, input int ab,
                         input int na, input int nb, input int scode, input int slen,
                         input int stall_mode);
    int nc, tbl, len, cycles, nbits, stall_cnt;
    bit ok, rdy, held_prev;
    logic hb, hl;
    logic [0:0] e;
    logic [CODE_W-1:0] code;
    string s;

    // Reference model.
    if (cdc != 0)               nc = -1;
    else if (aa != 0 && ab != 0) nc = (na + nb + 1) / 2;
    else if (aa != 0)           nc = na;
    else if (ab != 0)           nc = nb;
    else                        nc = 0;
    ok = (t1 <= tc) && (tc <= 16) && !(cdc != 0 && tc > 4);
    s = "";
    if (nc < 0) begin
      tbl = 3;
      if (ok) s = cd_tab[t1][tc];
    end else if (nc >= 8) begin
      tbl = 3;
      if (ok) s = (tc == 0) ? "000011" : $sformatf("%04b%02b", tc - 1, t1);
    end else begin
      tbl = (nc < 2) ? 0 : ((nc < 4) ? 1 : 2);
      if (slen < 1 || slen > CODE_W) ok = 1'b0;
      else for (int i = slen - 1; i >= 0; i--) s = {s, (((scode >> i) & 1) != 0) ? "1" : "0"};
    end
    len = s.len();
    code = '0;
    exp_q.delete();
    for (int i = 0; i < len; i++) begin
      code = {code[CODE_W-2:0], (s[i] == "1")};
      exp_q.push_back(s[i] == "1");
    end

    // Drive the symbol.
    @(negedge clk);
    totalCoeff = 5'(tc); trailingOnes = 2'(t1); chromaDc = (cdc != 0);
    availA = (aa != 0); availB = (ab != 0); nA = NC_W'(na); nB = NC_W'(nb);
    lutCode = CODE_W'(scode); lutLen = LEN_W'(slen);
    inValid = 1'b1;
    cycles = 0;
    while (!inReady && cycles < 50) begin
      @(negedge clk);
      cycles++;
    end
    check("accept_ready", 32'(inReady), 32'd1);
    @(posedge clk); #1;
    inValid = 1'b0;

    // LOOKUP cycle.
    check("lookup_busy", 32'(inReady), 32'd0);
    check("lut_addr", 32'(lutAddr), 32'({2'(t1), 5'(tc)}));
    if (nc >= 0 && nc < 8) check("lut_sel", 32'(lutSel), 32'(tbl));
    @(posedge clk); #1;

    if (!ok) begin
      check("err_pulse", 32'(errPulse), 32'd1);
      check("err_no_valid", 32'(outValid), 32'd0);
      check("err_code_kept", 32'(codeQ), 32'(last_code));
      check("err_len_kept", 32'(lenQ), 32'(last_len));
      check("err_ready", 32'(inReady), 32'd1);
      @(posedge clk); #1;
      check("err_one_cycle", 32'(errPulse), 32'd0);
      check("err_idle_valid", 32'(outValid), 32'd0);
      return;
    end

    check("code_q", 32'(codeQ), 32'(code));
    check("len_q", 32'(lenQ), 32'(len));
    check("tbl_sel_q", 32'(tblSelQ), 32'(tbl));
    check("no_err", 32'(errPulse), 32'd0);
    last_code = code;
    last_len = LEN_W'(len);

    // Serial phase.
    cycles = 0; nbits = 0; stall_cnt = 0; held_prev = 1'b0; hb = 1'b0; hl = 1'b0;
    while (exp_q.size() > 0 && cycles < 200) begin
      check("out_valid", 32'(outValid), 32'd1);
      if (held_prev) begin
        check("hold_bit", 32'(outBit), 32'(hb));
        check("hold_last", 32'(outLast), 32'(hl));
      end
      case (stall_mode)
        1:       rdy = ($urandom_range(0, 1) != 0);
        2:       rdy = !(nbits == 2 && stall_cnt < 3);
        default: rdy = 1'b1;
      endcase
      if (!rdy && stall_mode == 2) stall_cnt++;
      outReady = rdy;
      if (rdy) begin
        e = exp_q.pop_front();
        check("bit", 32'(outBit), 32'(e));
        check("last", 32'(outLast), 32'(exp_q.size() == 0));
        nbits++;
      end
      held_prev = !rdy;
      hb = outBit;
      hl = outLast;
      cycles++;
      @(posedge clk); #1;
    end
    if (exp_q.size() > 0) begin
      check("shift_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    outReady = 1'b0;
    check("ready_back", 32'(inReady), 32'd1);
    check("valid_off", 32'(outValid), 32'd0);
    check("last_off", 32'(outLast), 32'd0);
  endtask

  initial begin
    cd_tab[0][0] = "01";
    cd_tab[0][1] = "000111";  cd_tab[1][1] = "1";
    cd_tab[0][2] = "000100";  cd_tab[1][2] = "000110";   cd_tab[2][2] = "001";
    cd_tab[0][3] = "000011";  cd_tab[1][3] = "0000011";  cd_tab[2][3] = "0000010";  cd_tab[3][3] = "000101";
    cd_tab[0][4] = "000010";  cd_tab[1][4] = "00000011"; cd_tab[2][4] = "00000010"; cd_tab[3][4] = "0000000";

    // Reset state.
    #12;
    check("rst_in_ready", 32'(inReady), 32'd1);
    check("rst_code", 32'(codeQ), 32'd0);
    check("rst_len", 32'(lenQ), 32'd0);
    check("rst_tbl", 32'(tblSelQ), 32'd0);
    check("rst_valid", 32'(outValid), 32'd0);
    check("rst_bit", 32'(outBit), 32'd0);
    check("rst_last", 32'(outLast), 32'd0);
    check("rst_err", 32'(errPulse), 32'd0);
    check("rst_lut_addr", 32'(lutAddr), 32'd0);
    check("rst_lut_sel", 32'(lutSel), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases.
    run_sym(5, 2, 0, 1, 1, 9, 8, 0, 0, 0);       // FLC 010010
    run_sym(0, 0, 0, 1, 0, 12, 0, 0, 0, 0);      // FLC 000011
    run_sym(3, 1, 1, 0, 0, 0, 0, 0, 0, 0);       // Chroma DC 0000011
    run_sym(1, 1, 1, 1, 1, 5, 5, 0, 0, 0);       // Chroma DC single bit
    run_sym(4, 1, 0, 1, 0, 3, 0, 'h0F, 6, 0);    // VLC1 via stub
    run_sym(4, 1, 0, 1, 0, 3, 0, 'h0F, 6, 2);    // backpressure after 2nd bit
    run_sym(16, 3, 0, 0, 1, 0, 16, 0, 0, 2);     // FLC, largest TC
    run_sym(2, 3, 0, 0, 0, 0, 0, 5, 5, 0);       // T1s > TC
    run_sym(3, 0, 0, 0, 0, 0, 0, 0, 0, 0);       // lutLen = 0
    run_sym(3, 0, 0, 1, 1, 6, 7, 3, 17, 0);      // lutLen > CODE_W
    run_sym(5, 0, 1, 0, 0, 0, 0, 0, 0, 0);       // chroma TC > 4
    run_sym(17, 0, 0, 1, 0, 10, 0, 0, 0, 0);     // TC > 16
    run_sym(0, 0, 0, 1, 1, 16, 16, 'hABCD, 16, 1); // nC = 16, FLC

    // Reset mid-SHIFT.
    @(negedge clk);
    totalCoeff = 5'd5; trailingOnes = 2'd2; chromaDc = 1'b0;
    availA = 1'b1; availB = 1'b0; nA = NC_W'(9); inValid = 1'b1;
    @(posedge clk); #1;
    inValid = 1'b0;
    @(posedge clk); #1;
    outReady = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("abort_valid", 32'(outValid), 32'd0);
    check("abort_ready", 32'(inReady), 32'd1);
    check("abort_last", 32'(outLast), 32'd0);
    check("abort_code", 32'(codeQ), 32'd0);
    check("abort_len", 32'(lenQ), 32'd0);
    check("abort_lut_addr", 32'(lutAddr), 32'd0);
    outReady = 1'b0;
    last_code = '0;
    last_len = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized symbols.
    for (int n = 0; n < 300; n++) begin
      int tc, t1, cdc, slen, scode;
      tc = $urandom_range(0, 18);
      t1 = $urandom_range(0, 3);
      cdc = ($urandom_range(0, 3) == 0) ? 1 : 0;
      if (cdc != 0 && $urandom_range(0, 3) != 0) tc = $urandom_range(0, 4);
      if ($urandom_range(0, 7) != 0 && t1 > tc) t1 = tc;
      slen = ($urandom_range(0, 15) == 0) ? $urandom_range(0, 20) : $urandom_range(1, CODE_W);
      scode = int'($urandom_range(0, 65535));
      if (slen >= 1 && slen < 32) scode = scode & ((1 << slen) - 1);
      run_sym(tc, t1, cdc, $urandom_range(0, 1), $urandom_range(0, 1),
              $urandom_range(0, 16), $urandom_range(0, 16), scode, slen, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time limit.
  initial begin
    #2000000;
    $display("FAIL timeout observed running expected finished");
    $fatal(1, "time limit");
  end

endmodule
